// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: single-clock timing controller for the game logic.
// Divides clk_20MHz into a base tick, then emits one-cycle enables for the
// ship, bullet and asteroid updates under a RUN/PAUSED/IDLE FSM. Asteroid
// rate speeds up with a 3-bit level that advances every LEVEL_TICKS asteroid ticks.
// Optional: define TICK_HEARTBEAT_EN to add a heartbeat output that toggles
// every 500 base ticks in RUN.
module game_tick_scheduler #(
    parameter int PRESCALE    = 5000,
    parameter int SHIP_DIV    = 100,
    parameter int BULLET_DIV  = 40,
    parameter int AST_DIV     = 400,
    parameter int AST_STEP    = 40,
    parameter int AST_MIN     = 80,
    parameter int LEVEL_TICKS = 64
) (
    input  logic       clk_20MHz,
    input  logic       rst,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       game_over,
    output logic       tick_ship,
    output logic       tick_bullet,
    output logic       tick_ast,
    output logic [2:0] level,
    output logic       running,
`ifdef TICK_HEARTBEAT_EN
    output logic       paused,
    output logic       heartbeat
`else
    output logic       paused
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [15:0] PRE_LAST    = 16'(PRESCALE - 1);
    localparam logic [15:0] SHIP_LAST   = 16'(SHIP_DIV - 1);
    localparam logic [15:0] BULLET_LAST = 16'(BULLET_DIV - 1);
    localparam logic [15:0] LVL_LAST    = 16'(LEVEL_TICKS - 1);
    localparam logic signed [16:0] AST_DIV_S  = 17'(AST_DIV);
    localparam logic signed [16:0] AST_STEP_S = 17'(AST_STEP);
    localparam logic signed [16:0] AST_MIN_S  = 17'(AST_MIN);

    state_t state, next_state;

    logic [15:0] pre_cnt;
    logic [15:0] ship_cnt;
    logic [15:0] bullet_cnt;
    logic [15:0] ast_cnt;
    logic [15:0] lvl_cnt;

    logic               clear_cnt;
    logic               count_en;
    logic               emit;
    logic               base_tick;
    logic               ship_wrap;
    logic               bullet_wrap;
    logic               ast_wrap;
    logic signed [16:0] level_s;
    logic signed [16:0] ast_calc;
    logic [15:0]        ast_period;
    logic [15:0]        ast_last;

    // State register; rst returns the game to IDLE
    always_ff @(posedge clk_20MHz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: game_over outranks pause_toggle, start only acts from IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (game_over) begin
                    next_state = IDLE;
                end else if (pause_toggle) begin
                    next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (game_over) begin
                    next_state = IDLE;
                end else if (pause_toggle) begin
                    next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Counting happens on RUN edges unless the game is ending this edge;
    // the pause edge still counts so a resumed game loses no base ticks,
    // but a tick that would land inside PAUSED is not emitted.
    assign clear_cnt   = (next_state == IDLE);
    assign count_en    = (state == RUN) && !clear_cnt;
    assign emit        = (state == RUN) && (next_state == RUN);
    assign base_tick   = (state == RUN) && (pre_cnt == PRE_LAST);
    assign ship_wrap   = base_tick && (ship_cnt == SHIP_LAST);
    assign bullet_wrap = base_tick && (bullet_cnt == BULLET_LAST);
    assign ast_wrap    = base_tick && (ast_cnt == ast_last);

    // Signed arithmetic lets deep levels underflow cleanly into the floor
    assign level_s    = $signed({14'd0, level});
    assign ast_calc   = AST_DIV_S - (level_s * AST_STEP_S);
    assign ast_period = (ast_calc < AST_MIN_S) ? 16'(AST_MIN) : ast_calc[15:0];
    assign ast_last   = ast_period - 16'd1;

    // Prescaler from clk_20MHz to the base tick
    always_ff @(posedge clk_20MHz) begin
        if (rst || clear_cnt) begin
            pre_cnt <= 16'd0;
        end else if (count_en) begin
            pre_cnt <= base_tick ? 16'd0 : pre_cnt + 16'd1;
        end
    end

    // Per-channel base-tick counters and their registered tick pulses
    always_ff @(posedge clk_20MHz) begin
        if (rst || clear_cnt) begin
            ship_cnt    <= 16'd0;
            bullet_cnt  <= 16'd0;
            ast_cnt     <= 16'd0;
            tick_ship   <= 1'b0;
            tick_bullet <= 1'b0;
            tick_ast    <= 1'b0;
        end else begin
            tick_ship   <= emit && ship_wrap;
            tick_bullet <= emit && bullet_wrap;
            tick_ast    <= emit && ast_wrap;
            if (count_en && base_tick) begin
                ship_cnt   <= ship_wrap   ? 16'd0 : ship_cnt + 16'd1;
                bullet_cnt <= bullet_wrap ? 16'd0 : bullet_cnt + 16'd1;
                ast_cnt    <= ast_wrap    ? 16'd0 : ast_cnt + 16'd1;
            end
        end
    end

    // Difficulty level: advances every LEVEL_TICKS asteroid wraps, saturates at 7
    always_ff @(posedge clk_20MHz) begin
        if (rst || (state == IDLE && start)) begin
            level   <= 3'd0;
            lvl_cnt <= 16'd0;
        end else if (count_en && ast_wrap) begin
            if (level == 3'd7) begin
                lvl_cnt <= 16'd0;
            end else if (lvl_cnt == LVL_LAST) begin
                level   <= level + 3'd1;
                lvl_cnt <= 16'd0;
            end else begin
                lvl_cnt <= lvl_cnt + 16'd1;
            end
        end
    end

    // Registered state decodes, aligned with the state they describe
    always_ff @(posedge clk_20MHz) begin
        if (rst) begin
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            running <= (next_state == RUN);
            paused  <= (next_state == PAUSED);
        end
    end

`ifdef TICK_HEARTBEAT_EN
    logic [8:0] hb_cnt;

    // Heartbeat square wave: toggles every 500 base ticks, frozen in PAUSED
    always_ff @(posedge clk_20MHz) begin
        if (rst || clear_cnt) begin
            hb_cnt    <= 9'd0;
            heartbeat <= 1'b0;
        end else if (count_en && base_tick) begin
            if (hb_cnt == 9'd499) begin
                hb_cnt    <= 9'd0;
                heartbeat <= ~heartbeat;
            end else begin
                hb_cnt <= hb_cnt + 9'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed and randomized stimulus for
// game_tick_scheduler, checked against a behavioural model that tracks
// base ticks since game start and the scheduled asteroid deadline.
// Define TICK_HEARTBEAT_EN to also check the heartbeat output.
module tb_game_tick_scheduler;

    localparam int P  = 4;
    localparam int SD = 3;
    localparam int BD = 2;
    localparam int AD = 10;
    localparam int AS = 4;
    localparam int AM = 3;
    localparam int LT = 2;

    logic       clk_20MHz = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause_toggle = 1'b0;
    logic       game_over = 1'b0;
    logic       tick_ship;
    logic       tick_bullet;
    logic       tick_ast;
    logic [2:0] level;
    logic       running;
    logic       paused;
`ifdef TICK_HEARTBEAT_EN
    logic       heartbeat;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: mode 0=idle 1=run 2=paused
    int m_mode = 0;
    int m_edges = 0;
    int m_base = 0;
    int m_next_ast = 0;
    int m_ast_count = 0;
    int m_level = 0;
    bit m_ts = 0;
    bit m_tb = 0;
    bit m_ta = 0;
    bit m_hb = 0;

    game_tick_scheduler #(
        .PRESCALE(P), .SHIP_DIV(SD), .BULLET_DIV(BD),
        .AST_DIV(AD), .AST_STEP(AS), .AST_MIN(AM), .LEVEL_TICKS(LT)
    ) dut (
        .clk_20MHz(clk_20MHz),
        .rst(rst),
        .start(start),
        .pause_toggle(pause_toggle),
        .game_over(game_over),
        .tick_ship(tick_ship),
        .tick_bullet(tick_bullet),
        .tick_ast(tick_ast),
        .level(level),
        .running(running),
`ifdef TICK_HEARTBEAT_EN
        .paused(paused),
        .heartbeat(heartbeat)
`else
        .paused(paused)
`endif
    );

    // Free-running 100 MHz-style bench clock
    always #5 clk_20MHz = ~clk_20MHz;

    function automatic int astPeriod(input int lvl);
        int p;
        p = AD - lvl * AS;
        return (p < AM) ? AM : p;
    endfunction

    // Reference model: one call per clock edge with the inputs sampled there
    task automatic modelStep(input bit r, input bit s, input bit pt, input bit go);
        bit fs, fb, fa;
        m_ts = 0; m_tb = 0; m_ta = 0;
        if (r) begin
            m_mode = 0; m_edges = 0; m_base = 0; m_level = 0;
            m_ast_count = 0; m_hb = 0;
        end else begin
            case (m_mode)
                0: if (s) begin
                    m_mode = 1; m_level = 0; m_ast_count = 0;
                    m_edges = 0; m_base = 0; m_hb = 0;
                    m_next_ast = astPeriod(0);
                end
                1: if (go) begin
                    m_mode = 0; m_edges = 0; m_base = 0; m_hb = 0;
                end else begin
                    m_edges++;
                    if (m_edges % P == 0) begin
                        m_base++;
                        fs = (m_base % SD == 0);
                        fb = (m_base % BD == 0);
                        fa = (m_base == m_next_ast);
                        if (m_base % 500 == 0) m_hb = ~m_hb;
                        if (fa) begin
                            m_ast_count++;
                            m_level = (m_ast_count / LT > 7) ? 7 : m_ast_count / LT;
                            m_next_ast = m_base + astPeriod(m_level);
                        end
                        if (!pt) begin
                            m_ts = fs; m_tb = fb; m_ta = fa;
                        end
                    end
                    if (pt) m_mode = 2;
                end
                default: if (go) begin
                    m_mode = 0; m_edges = 0; m_base = 0; m_hb = 0;
                end else if (pt) begin
                    m_mode = 1;
                end
            endcase
        end
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("tick_ship",   {7'd0, tick_ship},   {7'd0, m_ts});
        checkValue("tick_bullet", {7'd0, tick_bullet}, {7'd0, m_tb});
        checkValue("tick_ast",    {7'd0, tick_ast},    {7'd0, m_ta});
        checkValue("level",       {5'd0, level},       8'(m_level));
        checkValue("running",     {7'd0, running},     {7'd0, (m_mode == 1)});
        checkValue("paused",      {7'd0, paused},      {7'd0, (m_mode == 2)});
`ifdef TICK_HEARTBEAT_EN
        checkValue("heartbeat",   {7'd0, heartbeat},   {7'd0, m_hb});
`endif
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare
    task automatic applyStimulus(input bit r, input bit s, input bit pt, input bit go);
        rst = r; start = s; pause_toggle = pt; game_over = go;
        @(posedge clk_20MHz);
        modelStep(r, s, pt, go);
        #1;
        checkOutput();
    endtask

    initial begin
        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] idle ignores pause_toggle and game_over");
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] start, ship ticks every 12 cycles");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] pause at E0+5, resume at E0+25");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 19; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] level ramp to saturation");
        for (int i = 0; i < 400; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] game_over with pause_toggle, then restart");
        applyStimulus(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] reset on the cycle a ship tick is due");
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] long run for heartbeat, with a pause");
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 4100; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 50; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);

        $display("[TB] randomized control inputs");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 599) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
